// File: rtl/pipeline_hazard_ctrl.sv
// Data-hazard controller for a 5-stage pipeline: load-use / RAW stalls, branch flush, operand forwarding.
// Define FORWARDING_EN to enable EX/MEM and MEM/WB forwarding (otherwise every RAW hazard stalls).
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             load;
  } slot_t;

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [REG_W-1:0] ZERO_IDX  = REG_W'(ZERO_REG);
  localparam logic [1:0]       FWD_RF    = 2'b00;
  localparam logic [1:0]       FWD_EXMEM = 2'b10;
  localparam logic [1:0]       FWD_MEMWB = 2'b01;

  slot_t  ex_slot, mem_slot, wb_slot;
  state_t state;
  logic   ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic   hazard, stall;

  function automatic logic slot_match(slot_t s, logic [REG_W-1:0] src, logic used);
    return s.valid && (s.rd == src) && used && (src != ZERO_IDX);
  endfunction

  // The WB slot is never consulted: the register file writes before it is read.
  assign ex_hit_a  = slot_match(ex_slot,  id_rn, id_uses_rn);
  assign ex_hit_b  = slot_match(ex_slot,  id_rm, id_uses_rm);
  assign mem_hit_a = slot_match(mem_slot, id_rn, id_uses_rn);
  assign mem_hit_b = slot_match(mem_slot, id_rm, id_uses_rm);

`ifdef FORWARDING_EN
  assign hazard = (ex_hit_a || ex_hit_b) && ex_slot.load;
`else
  assign hazard = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
`endif

  assign stall = id_valid && hazard;

  // NOTE: every output gets a default first so no path through the if-chain can infer a latch.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      // reset values hold while reset is high, even mid-stall
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the slot shift reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
      state    <= RUN;
`ifdef FORWARDING_EN
      fwd_a    <= FWD_RF;
      fwd_b    <= FWD_RF;
`endif
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= idex_bubble ? '0 : slot_t'{id_valid && id_regwrite, id_rd, id_memtoreg};

      // STALL re-evaluates the hazard each cycle; a taken branch always returns to RUN.
      case (state)
        RUN:     state <= (stall && !ex_br_taken) ? STALL : RUN;
        STALL:   state <= (stall && !ex_br_taken) ? STALL : RUN;
        default: state <= RUN;
      endcase

`ifdef FORWARDING_EN
      if (idex_bubble) begin
        fwd_a <= FWD_RF;
        fwd_b <= FWD_RF;
      end else begin
        fwd_a <= ex_hit_a ? FWD_EXMEM : (mem_hit_a ? FWD_MEMWB : FWD_RF);
        fwd_b <= ex_hit_b ? FWD_EXMEM : (mem_hit_b ? FWD_MEMWB : FWD_RF);
      end
`endif
    end
  end

`ifndef FORWARDING_EN
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule
